// File: rtl/ram_access_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_access_arbiter_if
// Client-side bundle of the ram access arbiter: read request/grant/response
// and write request/grant for all clients, packed per client.
//   rd_req       [NUM_RD]              read request, held until rd_gnt
//   rd_addr      [NUM_RD*ADDR_WIDTH]   client i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_gnt       [NUM_RD]              one-hot read grant (combinational)
//   rd_rsp_valid [NUM_RD]              one-hot response valid (registered)
//   rd_rsp_data  [DATA_WIDTH]          shared response data
//   wr_req       [NUM_WR]              write request, held until wr_gnt
//   wr_addr      [NUM_WR*ADDR_WIDTH]   packed as rd_addr
//   wr_data      [NUM_WR*DATA_WIDTH]   client j data at [j*DATA_WIDTH +: DATA_WIDTH]
//   wr_gnt       [NUM_WR]              one-hot write grant; write happens that cycle
// master modport: the clients. slave modport: the arbiter.
// ---------------------------------------------------------------------------
interface ram_access_arbiter_if #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2
);
    logic [NUM_RD-1:0]            rd_req;
    logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_RD-1:0]            rd_gnt;
    logic [NUM_RD-1:0]            rd_rsp_valid;
    logic [DATA_WIDTH-1:0]        rd_rsp_data;
    logic [NUM_WR-1:0]            wr_req;
    logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_WR*DATA_WIDTH-1:0] wr_data;
    logic [NUM_WR-1:0]            wr_gnt;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  rd_gnt, rd_rsp_valid, rd_rsp_data, wr_gnt
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output rd_gnt, rd_rsp_valid, rd_rsp_data, wr_gnt
    );
endinterface

// File: rtl/ram_access_arbiter.sv
// ---------------------------------------------------------------------------
// ram_access_arbiter
// Shares one ram (one read port, one write port) among NUM_RD read clients
// and NUM_WR write clients with independent round-robin arbitration per port.
// Read data comes back to the granted client RD_LAT = 1 + OUTPUT_REG cycles
// after the grant.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   cli               client bundle (slave side)
//   ram_read_req/addr, ram_read_data     ram read port
//   ram_write_req/addr/data              ram write port
// ---------------------------------------------------------------------------
module ram_access_arbiter #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 12,
    parameter int OUTPUT_REG = 1,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    ram_access_arbiter_if.slave   cli,
    output logic                  ram_read_req,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    input  logic [DATA_WIDTH-1:0] ram_read_data,
    output logic                  ram_write_req,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [DATA_WIDTH-1:0] ram_write_data
);
    localparam int RD_LAT = 1 + OUTPUT_REG;
    localparam int RD_PW  = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int WR_PW  = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

    logic [ADDR_WIDTH-1:0] rd_addr_arr [NUM_RD];
    logic [ADDR_WIDTH-1:0] wr_addr_arr [NUM_WR];
    logic [DATA_WIDTH-1:0] wr_data_arr [NUM_WR];

    logic [RD_PW-1:0] rd_ptr_q, rd_ptr_d, rd_sel;
    logic [WR_PW-1:0] wr_ptr_q, wr_ptr_d, wr_sel;
    logic             rd_found, wr_found;
    logic             rd_grant, wr_grant, raw_hazard;
    logic [NUM_RD-1:0] rd_gnt_vec;
    logic [NUM_RD-1:0] pipe_q [RD_LAT];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd_client
            assign rd_addr_arr[gi] = cli.rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign rd_gnt_vec[gi]  = rd_grant && (rd_sel == RD_PW'(gi));
        end
        for (gi = 0; gi < NUM_WR; gi++) begin : g_wr_client
            assign wr_addr_arr[gi] = cli.wr_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wr_data_arr[gi] = cli.wr_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign cli.wr_gnt[gi]  = wr_grant && (wr_sel == WR_PW'(gi));
        end
    endgenerate

    // Round-robin search: first requester at or after the pointer, wrapping.
    always_comb begin
        int idx;
        idx      = 0;
        wr_sel   = '0;
        wr_found = 1'b0;
        for (int k = 0; k < NUM_WR; k++) begin
            idx = int'(wr_ptr_q) + k;
            if (idx >= NUM_WR) idx = idx - NUM_WR;
            if (!wr_found && cli.wr_req[idx]) begin
                wr_found = 1'b1;
                wr_sel   = WR_PW'(idx);
            end
        end
    end

    always_comb begin
        int idx;
        idx      = 0;
        rd_sel   = '0;
        rd_found = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            idx = int'(rd_ptr_q) + k;
            if (idx >= NUM_RD) idx = idx - NUM_RD;
            if (!rd_found && cli.rd_req[idx]) begin
                rd_found = 1'b1;
                rd_sel   = RD_PW'(idx);
            end
        end
    end

    // The ram returns old data on a same-cycle read/write to one address, so
    // the read candidate backs off for a cycle instead of returning stale data.
    // Only the round-robin candidate is considered; other readers wait too.
    assign wr_grant   = wr_found && !reset;
    assign raw_hazard = wr_grant && (rd_addr_arr[rd_sel] == wr_addr_arr[wr_sel]);
    assign rd_grant   = rd_found && !reset && !raw_hazard;

    assign cli.rd_gnt     = rd_gnt_vec;
    assign ram_read_req   = rd_grant;
    assign ram_read_addr  = rd_grant ? rd_addr_arr[rd_sel] : '0;
    assign ram_write_req  = wr_grant;
    assign ram_write_addr = wr_grant ? wr_addr_arr[wr_sel] : '0;
    assign ram_write_data = wr_grant ? wr_data_arr[wr_sel] : '0;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (rd_grant) rd_ptr_d = (int'(rd_sel) == NUM_RD - 1) ? '0 : rd_sel + 1'b1;
        if (wr_grant) wr_ptr_d = (int'(wr_sel) == NUM_WR - 1) ? '0 : wr_sel + 1'b1;
    end

    // The one-hot grant travels down the pipe; it carries both valid and
    // client id, and lines up with ram_read_data at the last stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int s = 0; s < RD_LAT; s++) pipe_q[s] <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            pipe_q[0] <= rd_gnt_vec;
            for (int s = 1; s < RD_LAT; s++) pipe_q[s] <= pipe_q[s-1];
        end
    end

    assign cli.rd_rsp_valid = pipe_q[RD_LAT-1];
    assign cli.rd_rsp_data  = ram_read_data;
endmodule

// File: tb/tb_ram_access_arbiter.sv
module tb_ram_access_arbiter;
    localparam int DW = 10;
    localparam int AW = 12;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // DUT A: OUTPUT_REG = 1 (RD_LAT 2); DUT B: OUTPUT_REG = 0 (RD_LAT 1)
    ram_access_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(2), .NUM_WR(2)) if_a ();
    ram_access_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(2), .NUM_WR(2)) if_b ();

    logic          a_rreq, a_wreq, b_rreq, b_wreq;
    logic [AW-1:0] a_raddr, a_waddr, b_raddr, b_waddr;
    logic [DW-1:0] a_rdata, a_wdata, b_rdata, b_wdata;

    ram_access_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUTPUT_REG(1), .NUM_RD(2), .NUM_WR(2)) dut_a (
        .clk(clk), .reset(reset), .cli(if_a.slave),
        .ram_read_req(a_rreq), .ram_read_addr(a_raddr), .ram_read_data(a_rdata),
        .ram_write_req(a_wreq), .ram_write_addr(a_waddr), .ram_write_data(a_wdata));

    ram_access_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUTPUT_REG(0), .NUM_RD(2), .NUM_WR(2)) dut_b (
        .clk(clk), .reset(reset), .cli(if_b.slave),
        .ram_read_req(b_rreq), .ram_read_addr(b_raddr), .ram_read_data(b_rdata),
        .ram_write_req(b_wreq), .ram_write_addr(b_waddr), .ram_write_data(b_wdata));

    // Ram models: read sees the contents before a same-cycle write.
    // A few words are loaded while reset is high.
    logic [DW-1:0] mem_a [4096];
    logic [DW-1:0] mem_b [4096];
    logic [DW-1:0] s1_a, s2_a, s1_b;

    always @(posedge clk) begin
        if (reset) begin
            mem_a[5] <= 10'h00F;
            mem_a[7] <= 10'h155;
            mem_a[8] <= 10'h0AB;
        end else if (a_wreq) begin
            mem_a[a_waddr] <= a_wdata;
        end
        s1_a <= mem_a[a_raddr];
        s2_a <= s1_a;
    end
    assign a_rdata = s2_a;

    always @(posedge clk) begin
        if (reset) mem_b[5] <= 10'h00F;
        else if (b_wreq) mem_b[b_waddr] <= b_wdata;
        s1_b <= mem_b[b_raddr];
    end
    assign b_rdata = s1_b;

    typedef struct {
        logic [1:0]    rd_req;
        logic [AW-1:0] ra0, ra1;
        logic [1:0]    wr_req;
        logic [AW-1:0] wa0, wa1;
        logic [DW-1:0] wd0, wd1;
        logic [1:0]    e_rgnt, e_wgnt;
        logic [AW-1:0] e_raddr, e_waddr;
        logic [DW-1:0] e_wdata;
        logic [1:0]    e_rsp;
        logic [DW-1:0] e_rdata;
    } vec_t;

    vec_t vt [24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [1:0] rq, input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        if_a.rd_req  = rq;
        if_a.rd_addr = {r1, r0};
    endtask

    initial begin
        //        rd   ra0  ra1   wr   wa0  wa1  wd0      wd1      rgnt  wgnt  raddr wadr wdata    rsp   rdata
        vt[0]  = '{2'b01, 5, 0, 2'b00, 0, 0, 10'h000, 10'h000, 2'b01, 2'b00, 5, 0, 10'h000, 2'b00, 10'h000};
        vt[1]  = '{2'b10, 0, 8, 2'b00, 0, 0, 10'h000, 10'h000, 2'b10, 2'b00, 8, 0, 10'h000, 2'b00, 10'h000};
        vt[2]  = '{2'b00, 0, 0, 2'b00, 0, 0, 10'h000, 10'h000, 2'b00, 2'b00, 0, 0, 10'h000, 2'b01, 10'h00F};
        vt[3]  = '{2'b11, 5, 8, 2'b00, 0, 0, 10'h000, 10'h000, 2'b01, 2'b00, 5, 0, 10'h000, 2'b10, 10'h0AB};
        vt[4]  = '{2'b11, 5, 8, 2'b00, 0, 0, 10'h000, 10'h000, 2'b10, 2'b00, 8, 0, 10'h000, 2'b00, 10'h000};
        vt[5]  = '{2'b11, 5, 8, 2'b00, 0, 0, 10'h000, 10'h000, 2'b01, 2'b00, 5, 0, 10'h000, 2'b01, 10'h00F};
        vt[6]  = '{2'b11, 5, 8, 2'b00, 0, 0, 10'h000, 10'h000, 2'b10, 2'b00, 8, 0, 10'h000, 2'b10, 10'h0AB};
        vt[7]  = '{2'b11, 5, 8, 2'b00, 0, 0, 10'h000, 10'h000, 2'b01, 2'b00, 5, 0, 10'h000, 2'b01, 10'h00F};
        vt[8]  = '{2'b11, 5, 8, 2'b00, 0, 0, 10'h000, 10'h000, 2'b10, 2'b00, 8, 0, 10'h000, 2'b10, 10'h0AB};
        vt[9]  = '{2'b00, 0, 0, 2'b00, 0, 0, 10'h000, 10'h000, 2'b00, 2'b00, 0, 0, 10'h000, 2'b01, 10'h00F};
        vt[10] = '{2'b00, 0, 0, 2'b00, 0, 0, 10'h000, 10'h000, 2'b00, 2'b00, 0, 0, 10'h000, 2'b10, 10'h0AB};
        vt[11] = '{2'b00, 0, 0, 2'b11, 3, 4, 10'h011, 10'h022, 2'b00, 2'b01, 0, 3, 10'h011, 2'b00, 10'h000};
        vt[12] = '{2'b00, 0, 0, 2'b10, 3, 4, 10'h011, 10'h022, 2'b00, 2'b10, 0, 4, 10'h022, 2'b00, 10'h000};
        vt[13] = '{2'b11, 3, 4, 2'b00, 0, 0, 10'h000, 10'h000, 2'b01, 2'b00, 3, 0, 10'h000, 2'b00, 10'h000};
        vt[14] = '{2'b10, 3, 4, 2'b00, 0, 0, 10'h000, 10'h000, 2'b10, 2'b00, 4, 0, 10'h000, 2'b00, 10'h000};
        vt[15] = '{2'b00, 0, 0, 2'b00, 0, 0, 10'h000, 10'h000, 2'b00, 2'b00, 0, 0, 10'h000, 2'b01, 10'h011};
        vt[16] = '{2'b00, 0, 0, 2'b00, 0, 0, 10'h000, 10'h000, 2'b00, 2'b00, 0, 0, 10'h000, 2'b10, 10'h022};
        vt[17] = '{2'b01, 7, 0, 2'b01, 7, 0, 10'h3AA, 10'h000, 2'b00, 2'b01, 0, 7, 10'h3AA, 2'b00, 10'h000};
        vt[18] = '{2'b01, 7, 0, 2'b00, 0, 0, 10'h000, 10'h000, 2'b01, 2'b00, 7, 0, 10'h000, 2'b00, 10'h000};
        vt[19] = '{2'b00, 0, 0, 2'b00, 0, 0, 10'h000, 10'h000, 2'b00, 2'b00, 0, 0, 10'h000, 2'b00, 10'h000};
        vt[20] = '{2'b00, 0, 0, 2'b00, 0, 0, 10'h000, 10'h000, 2'b00, 2'b00, 0, 0, 10'h000, 2'b01, 10'h3AA};
        vt[21] = '{2'b10, 0, 8, 2'b10, 0, 7, 10'h000, 10'h2C1, 2'b10, 2'b10, 8, 7, 10'h2C1, 2'b00, 10'h000};
        vt[22] = '{2'b00, 0, 0, 2'b00, 0, 0, 10'h000, 10'h000, 2'b00, 2'b00, 0, 0, 10'h000, 2'b00, 10'h000};
        vt[23] = '{2'b00, 0, 0, 2'b00, 0, 0, 10'h000, 10'h000, 2'b00, 2'b00, 0, 0, 10'h000, 2'b10, 10'h0AB};

        // Reset with requests pending: everything must stay quiet.
        reset = 1'b1;
        drive_a(2'b11, 12'd5, 12'd8);
        if_a.wr_req = 2'b11; if_a.wr_addr = {12'd4, 12'd3}; if_a.wr_data = {10'h022, 10'h011};
        if_b.rd_req = 2'b01; if_b.rd_addr = {12'd0, 12'd5};
        if_b.wr_req = 2'b00; if_b.wr_addr = '0; if_b.wr_data = '0;
        @(negedge clk);
        chk("reset a rd_gnt", 32'(if_a.rd_gnt), 0);
        chk("reset a wr_gnt", 32'(if_a.wr_gnt), 0);
        chk("reset a ram_read_req", 32'(a_rreq), 0);
        chk("reset a ram_write_req", 32'(a_wreq), 0);
        chk("reset a rd_rsp_valid", 32'(if_a.rd_rsp_valid), 0);
        chk("reset b rd_gnt", 32'(if_b.rd_gnt), 0);
        chk("reset b rd_rsp_valid", 32'(if_b.rd_rsp_valid), 0);
        $display("reset cycle: a.rd_gnt=%b a.wr_gnt=%b b.rd_gnt=%b", if_a.rd_gnt, if_a.wr_gnt, if_b.rd_gnt);
        next_cycle();
        reset = 1'b0;
        if_b.rd_req = 2'b00;

        for (int r = 0; r < 24; r++) begin
            drive_a(vt[r].rd_req, vt[r].ra0, vt[r].ra1);
            if_a.wr_req  = vt[r].wr_req;
            if_a.wr_addr = {vt[r].wa1, vt[r].wa0};
            if_a.wr_data = {vt[r].wd1, vt[r].wd0};
            @(negedge clk);
            $display("row %0d: rd_gnt=%b wr_gnt=%b rsp_valid=%b rsp_data=%h raddr=%0d waddr=%0d wdata=%h",
                     r, if_a.rd_gnt, if_a.wr_gnt, if_a.rd_rsp_valid, if_a.rd_rsp_data, a_raddr, a_waddr, a_wdata);
            chk($sformatf("row%0d rd_gnt", r), 32'(if_a.rd_gnt), 32'(vt[r].e_rgnt));
            chk($sformatf("row%0d wr_gnt", r), 32'(if_a.wr_gnt), 32'(vt[r].e_wgnt));
            chk($sformatf("row%0d ram_read_req", r), 32'(a_rreq), 32'(|vt[r].e_rgnt));
            chk($sformatf("row%0d ram_read_addr", r), 32'(a_raddr), 32'(vt[r].e_raddr));
            chk($sformatf("row%0d ram_write_req", r), 32'(a_wreq), 32'(|vt[r].e_wgnt));
            chk($sformatf("row%0d ram_write_addr", r), 32'(a_waddr), 32'(vt[r].e_waddr));
            chk($sformatf("row%0d ram_write_data", r), 32'(a_wdata), 32'(vt[r].e_wdata));
            chk($sformatf("row%0d rd_rsp_valid", r), 32'(if_a.rd_rsp_valid), 32'(vt[r].e_rsp));
            if (vt[r].e_rsp != 2'b00)
                chk($sformatf("row%0d rd_rsp_data", r), 32'(if_a.rd_rsp_data), 32'(vt[r].e_rdata));
            next_cycle();
        end
        if_a.wr_req = 2'b00;

        // Reset mid-flight: grant client 0, reset next cycle, expect no
        // response and the pointer back at client 0.
        drive_a(2'b01, 12'd5, 12'd0);
        @(negedge clk);
        chk("midrst grant", 32'(if_a.rd_gnt), 32'h1);
        $display("midrst t0: rd_gnt=%b", if_a.rd_gnt);
        next_cycle();
        reset = 1'b1;
        drive_a(2'b11, 12'd8, 12'd5);
        @(negedge clk);
        chk("midrst gnt during reset", 32'(if_a.rd_gnt), 0);
        chk("midrst read_req during reset", 32'(a_rreq), 0);
        chk("midrst rsp during reset", 32'(if_a.rd_rsp_valid), 0);
        $display("midrst t0+1: rd_gnt=%b rsp_valid=%b", if_a.rd_gnt, if_a.rd_rsp_valid);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst dropped rsp", 32'(if_a.rd_rsp_valid), 0);
        chk("midrst ptr reset grant", 32'(if_a.rd_gnt), 32'h1);
        chk("midrst ptr reset addr", 32'(a_raddr), 32'd8);
        $display("midrst t0+2: rd_gnt=%b rsp_valid=%b", if_a.rd_gnt, if_a.rd_rsp_valid);
        next_cycle();
        drive_a(2'b00, 12'd0, 12'd0);
        @(negedge clk);
        chk("midrst t0+3 rsp", 32'(if_a.rd_rsp_valid), 0);
        next_cycle();
        @(negedge clk);
        chk("midrst new rsp valid", 32'(if_a.rd_rsp_valid), 32'h1);
        chk("midrst new rsp data", 32'(if_a.rd_rsp_data), 32'h0AB);
        $display("midrst t0+4: rsp_valid=%b rsp_data=%h", if_a.rd_rsp_valid, if_a.rd_rsp_data);
        next_cycle();

        // OUTPUT_REG = 0 build: single read of addr 5, response one cycle later.
        if_b.rd_req = 2'b01; if_b.rd_addr = {12'd0, 12'd5};
        @(negedge clk);
        chk("lat1 grant", 32'(if_b.rd_gnt), 32'h1);
        chk("lat1 rsp at t0", 32'(if_b.rd_rsp_valid), 0);
        $display("lat1 t0: rd_gnt=%b", if_b.rd_gnt);
        next_cycle();
        if_b.rd_req = 2'b00;
        @(negedge clk);
        chk("lat1 rsp valid", 32'(if_b.rd_rsp_valid), 32'h1);
        chk("lat1 rsp data", 32'(if_b.rd_rsp_data), 32'h00F);
        $display("lat1 t0+1: rsp_valid=%b rsp_data=%h", if_b.rd_rsp_valid, if_b.rd_rsp_data);
        next_cycle();
        @(negedge clk);
        chk("lat1 rsp single pulse", 32'(if_b.rd_rsp_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
